// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction fetch controller.
// Imported by the fetch controller and by anything that decodes fetch_state.
package imem_fetch_ctrl_pkg;

   localparam int WORD_SIZE       = 19;
   localparam int IMEM_ADDR_WIDTH = 10;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_VALID   = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: owns the PC, buffers one fetched word for
// decode, and lends the memory port to the program loader while idle.
module imem_fetch_ctrl #(
   parameter int ADDR_WIDTH = imem_fetch_ctrl_pkg::IMEM_ADDR_WIDTH,
   parameter int WORD_SIZE  = imem_fetch_ctrl_pkg::WORD_SIZE
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  start,
   input  logic                  halt,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  ld_req,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [WORD_SIZE-1:0]  ld_data,
   output logic                  ld_gnt,
   output logic                  imem_rd_en,
   output logic                  imem_wr_en,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [WORD_SIZE-1:0]  imem_wdata,
   input  logic [WORD_SIZE-1:0]  imem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [WORD_SIZE-1:0]  instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic [1:0]            fetch_state
);
   import imem_fetch_ctrl_pkg::*;

   fetch_state_t          r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [WORD_SIZE-1:0]  r_instr;
   logic [ADDR_WIDTH-1:0] r_instr_pc;
   logic                  r_valid;

   fetch_state_t          w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;
   logic                  w_valid_nxt;
   logic                  w_load;
   logic                  w_accept;

   assign w_accept = (r_state == S_VALID) && r_valid && instr_ready;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_valid <= w_valid_nxt;
         if (w_load) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_valid_nxt = r_valid;
      w_load      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start && !ld_req) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: w_state_nxt = S_CAPTURE;
         S_CAPTURE: begin
            w_state_nxt = S_VALID;
            w_valid_nxt = 1'b1;
            w_load      = 1'b1;
         end
         S_VALID: begin
            if (w_accept) begin
               w_state_nxt = S_ISSUE;
               w_valid_nxt = 1'b0;
               w_pc_nxt    = r_pc + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Redirect drops any read in flight; halt overrides its state change.
      if (r_state != S_IDLE) begin
         if (redirect) begin
            w_state_nxt = S_ISSUE;
            w_pc_nxt    = redirect_pc;
            w_valid_nxt = 1'b0;
            w_load      = 1'b0;
         end
         if (halt) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_load      = 1'b0;
            if (!redirect) w_pc_nxt = r_pc;
         end
      end
   end

   always_comb begin
      ld_gnt     = 1'b0;
      imem_rd_en = 1'b0;
      imem_wr_en = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      unique case (r_state)
         S_IDLE: begin
            if (ld_req) begin
               ld_gnt     = 1'b1;
               imem_wr_en = 1'b1;
               imem_addr  = ld_addr;
               imem_wdata = ld_data;
            end
         end
         S_ISSUE: begin
            imem_rd_en = 1'b1;
            imem_addr  = r_pc;
         end
         default: ;
      endcase
   end

   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign fetch_state = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 1-cycle-latency
// instruction memory attached to the imem_* port.
module tb_imem_fetch_ctrl;

   localparam int AW = 10;
   localparam int WS = 19;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          start = 1'b0;
   logic          halt = 1'b0;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          ld_req = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [WS-1:0] ld_data = '0;
   logic          ld_gnt;
   logic          imem_rd_en;
   logic          imem_wr_en;
   logic [AW-1:0] imem_addr;
   logic [WS-1:0] imem_wdata;
   logic [WS-1:0] imem_rdata = '0;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic [WS-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic [1:0]    fetch_state;

   int errors = 0;
   int checks = 0;

   logic [WS-1:0] mem [1024];

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (imem_wr_en) mem[imem_addr] <= imem_wdata;
      if (imem_rd_en) imem_rdata <= mem[imem_addr];
   end

   imem_fetch_ctrl #(.ADDR_WIDTH(AW), .WORD_SIZE(WS)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .start(start), .halt(halt),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_gnt(ld_gnt), .imem_rd_en(imem_rd_en), .imem_wr_en(imem_wr_en),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .fetch_state(fetch_state)
   );

   // Advance one cycle: land 1 time unit after the falling edge.
   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic load_word(input logic [AW-1:0] a, input logic [WS-1:0] d);
      ld_req  = 1'b1;
      ld_addr = a;
      ld_data = d;
      #1;
      checks++;
      if (ld_gnt !== 1'b1 || imem_wr_en !== 1'b1 || imem_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL load_gnt a=%0d gnt=%b wr=%b rd=%b want 1 1 0",
                  a, ld_gnt, imem_wr_en, imem_rd_en);
      end
      step();
      ld_req = 1'b0;
      #1;
   endtask

   task automatic go_idle();
      halt = 1'b1;
      step();
      halt = 1'b0;
      #1;
      checks++;
      if (fetch_state !== 2'd0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_idle state=%0d valid=%b want 0 0",
                  fetch_state, instr_valid);
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      step();
      step();
      RESET_N = 1'b1;
      #1;
      checks++;
      if (fetch_state !== 2'd0 || instr_valid !== 1'b0 ||
          instr !== '0 || instr_pc !== '0) begin
         errors++;
         $display("FAIL reset_regs st=%0d v=%b i=%h pc=%0d want 0 0 0 0",
                  fetch_state, instr_valid, instr, instr_pc);
      end
      checks++;
      if (imem_rd_en !== 1'b0 || imem_wr_en !== 1'b0 || ld_gnt !== 1'b0 ||
          imem_addr !== '0 || imem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_comb rd=%b wr=%b gnt=%b a=%0d d=%h want zeros",
                  imem_rd_en, imem_wr_en, ld_gnt, imem_addr, imem_wdata);
      end
   endtask

   task automatic test_loader();
      ld_req  = 1'b1;
      ld_addr = 10'd5;
      ld_data = 19'h1ABCD;
      #1;
      checks++;
      if (ld_gnt !== 1'b1 || imem_wr_en !== 1'b1 || imem_rd_en !== 1'b0 ||
          imem_addr !== 10'd5 || imem_wdata !== 19'h1ABCD) begin
         errors++;
         $display("FAIL ld_write gnt=%b wr=%b rd=%b a=%0d d=%h want 1 1 0 5 1abcd",
                  ld_gnt, imem_wr_en, imem_rd_en, imem_addr, imem_wdata);
      end
      step();
      ld_req = 1'b0;
      #1;
      checks++;
      if (mem[5] !== 19'h1ABCD || fetch_state !== 2'd0) begin
         errors++;
         $display("FAIL ld_effect mem5=%h st=%0d want 1abcd 0",
                  mem[5], fetch_state);
      end
   endtask

   task automatic test_fetch_seq();
      for (int i = 0; i < 5; i++)
         load_word(AW'(i), 19'h00A00 + WS'(i));
      start = 1'b1;
      instr_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (imem_rd_en !== 1'b1 || imem_addr !== AW'(i) ||
             fetch_state !== 2'd1) begin
            errors++;
            $display("FAIL fetch_issue%0d rd=%b a=%0d st=%0d want 1 %0d 1",
                     i, imem_rd_en, imem_addr, fetch_state, i);
         end
         step();
         checks++;
         if (instr_valid !== 1'b0 || fetch_state !== 2'd2) begin
            errors++;
            $display("FAIL fetch_cap%0d v=%b st=%0d want 0 2",
                     i, instr_valid, fetch_state);
         end
         step();
         checks++;
         if (instr_valid !== 1'b1 || instr !== 19'h00A00 + WS'(i) ||
             instr_pc !== AW'(i)) begin
            errors++;
            $display("FAIL fetch_valid%0d v=%b i=%h pc=%0d want 1 %h %0d",
                     i, instr_valid, instr, instr_pc, 19'h00A00 + WS'(i), i);
         end
         step();
      end
   endtask

   task automatic test_stall();
      logic [WS-1:0] held_i;
      logic [AW-1:0] held_pc;
      instr_ready = 1'b0;
      step();
      step();
      held_i  = 19'h00A04;
      held_pc = 10'd4;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr !== held_i || instr_pc !== held_pc ||
             imem_rd_en !== 1'b0 || fetch_state !== 2'd3) begin
            errors++;
            $display("FAIL stall_hold%0d v=%b i=%h pc=%0d rd=%b st=%0d want 1 %h %0d 0 3",
                     k, instr_valid, instr, instr_pc, imem_rd_en, fetch_state,
                     held_i, held_pc);
         end
         step();
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      #1;
      checks++;
      if (imem_rd_en !== 1'b1 || imem_addr !== 10'd5 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_release rd=%b a=%0d v=%b want 1 5 0",
                  imem_rd_en, imem_addr, instr_valid);
      end
      go_idle();
   endtask

   task automatic test_redirect_wrap();
      load_word(10'd1023, 19'h7F3FF);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      redirect    = 1'b1;
      redirect_pc = 10'd1023;
      step();
      redirect = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || fetch_state !== 2'd1 ||
          imem_rd_en !== 1'b1 || imem_addr !== 10'd1023) begin
         errors++;
         $display("FAIL redir_cap v=%b st=%0d rd=%b a=%0d want 0 1 1 1023",
                  instr_valid, fetch_state, imem_rd_en, imem_addr);
      end
      step();
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 19'h7F3FF || instr_pc !== 10'd1023) begin
         errors++;
         $display("FAIL redir_valid v=%b i=%h pc=%0d want 1 7f3ff 1023",
                  instr_valid, instr, instr_pc);
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      #1;
      checks++;
      if (imem_rd_en !== 1'b1 || imem_addr !== 10'd0) begin
         errors++;
         $display("FAIL pc_wrap rd=%b a=%0d want 1 0", imem_rd_en, imem_addr);
      end
      step();
      step();
      checks++;
      if (instr !== 19'h00A00 || instr_pc !== 10'd0 || instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap_valid i=%h pc=%0d v=%b want a00 0 1",
                  instr, instr_pc, instr_valid);
      end
      go_idle();
   endtask

   task automatic test_halt_redirect();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      halt        = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 10'd40;
      step();
      halt     = 1'b0;
      redirect = 1'b0;
      #1;
      checks++;
      if (fetch_state !== 2'd0 || instr_valid !== 1'b0 || imem_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL halt_redir st=%0d v=%b rd=%b want 0 0 0",
                  fetch_state, instr_valid, imem_rd_en);
      end
      load_word(10'd40, 19'h2D2D2);
      start = 1'b1;
      step();
      start = 1'b0;
      #1;
      checks++;
      if (imem_rd_en !== 1'b1 || imem_addr !== 10'd40) begin
         errors++;
         $display("FAIL resume40 rd=%b a=%0d want 1 40", imem_rd_en, imem_addr);
      end
      step();
      step();
      checks++;
      if (instr !== 19'h2D2D2 || instr_pc !== 10'd40 || instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL resume_valid i=%h pc=%0d v=%b want 2d2d2 40 1",
                  instr, instr_pc, instr_valid);
      end
      go_idle();
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      RESET_N = 1'b0;
      step();
      RESET_N = 1'b1;
      #1;
      checks++;
      if (fetch_state !== 2'd0 || instr_valid !== 1'b0 ||
          instr_pc !== '0 || instr !== '0) begin
         errors++;
         $display("FAIL reset_mid st=%0d v=%b pc=%0d i=%h want 0 0 0 0",
                  fetch_state, instr_valid, instr_pc, instr);
      end
      start   = 1'b1;
      ld_req  = 1'b1;
      ld_addr = 10'd7;
      ld_data = 19'h05A5A;
      #1;
      checks++;
      if (ld_gnt !== 1'b1 || imem_wr_en !== 1'b1 || imem_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL start_ld gnt=%b wr=%b rd=%b want 1 1 0",
                  ld_gnt, imem_wr_en, imem_rd_en);
      end
      step();
      ld_req = 1'b0;
      #1;
      checks++;
      if (fetch_state !== 2'd0 || mem[7] !== 19'h05A5A) begin
         errors++;
         $display("FAIL start_ignored st=%0d mem7=%h want 0 05a5a",
                  fetch_state, mem[7]);
      end
      step();
      start = 1'b0;
      #1;
      checks++;
      if (imem_rd_en !== 1'b1 || imem_addr !== 10'd0 || fetch_state !== 2'd1) begin
         errors++;
         $display("FAIL pc_after_reset rd=%b a=%0d st=%0d want 1 0 1",
                  imem_rd_en, imem_addr, fetch_state);
      end
      go_idle();
   endtask

   initial begin
      step();
      test_reset();
      test_loader();
      test_fetch_seq();
      test_stall();
      test_redirect_wrap();
      test_halt_redirect();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
